// File: rtl/hdc_assoc_search_pkg.sv
// Shared definitions for the HDC associative search stage.
// Contents: class labels, the default dimension, FSM states and the label decision helper.
package hdc_assoc_search_pkg;

    localparam logic [1:0] LABEL_HAM     = 2'b00;
    localparam logic [1:0] LABEL_SPAM    = 2'b01;
    localparam logic [1:0] LABEL_INCONCL = 2'b11;

    localparam int HDC_DIM = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCUM  = 2'b01,
        ST_DECIDE = 2'b10
    } state_e;

    // A class wins only when it is closer by more than the margin; ties are inconclusive.
    function automatic logic [1:0] classify_label(input logic [31:0] d_ham,
                                                  input logic [31:0] d_spam,
                                                  input logic [31:0] margin);
        logic [1:0] label;
        if ((d_ham + margin) < d_spam) begin
            label = LABEL_HAM;
        end else if ((d_spam + margin) < d_ham) begin
            label = LABEL_SPAM;
        end else begin
            label = LABEL_INCONCL;
        end
        return label;
    endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational population count of a W-bit word.
module hdc_popcount #(
    parameter int W  = 64,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    // Sum of all set bits.
    always_comb begin
        count = {CW{1'b0}};
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/hdc_assoc_search.sv
// Associative memory stage: Hamming distance of a query to HAM and SPAM prototypes,
// accumulated CHUNK bits per cycle, then a ham/spam/inconclusive decision.
module hdc_assoc_search
    import hdc_assoc_search_pkg::*;
#(
    parameter int DIM    = HDC_DIM,
    parameter int CHUNK  = 64,
    parameter int MARGIN = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIM-1:0]           query,
    input  logic [DIM-1:0]           ham_hv,
    input  logic [DIM-1:0]           spam_hv,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               result,
    output logic [$clog2(DIM+1)-1:0] dist_ham,
    output logic [$clog2(DIM+1)-1:0] dist_spam
);

    localparam int N  = DIM / CHUNK;
    localparam int DW = $clog2(DIM + 1);
    localparam int CW = $clog2(CHUNK + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_e           state_r;
    state_e           state_next_s;
    logic [DIM-1:0]   qreg_r;
    logic [DIM-1:0]   hreg_r;
    logic [DIM-1:0]   sreg_r;
    logic [DW-1:0]    acc_h_r;
    logic [DW-1:0]    acc_s_r;
    logic [IW-1:0]    idx_r;
    logic             busy_r;
    logic             done_r;
    logic [1:0]       result_r;
    logic [DW-1:0]    dist_ham_r;
    logic [DW-1:0]    dist_spam_r;
    logic [CHUNK-1:0] xor_h_s;
    logic [CHUNK-1:0] xor_s_s;
    logic [CW-1:0]    cnt_h_s;
    logic [CW-1:0]    cnt_s_s;
    logic             last_s;

    assign xor_h_s = qreg_r[idx_r*CHUNK +: CHUNK] ^ hreg_r[idx_r*CHUNK +: CHUNK];
    assign xor_s_s = qreg_r[idx_r*CHUNK +: CHUNK] ^ sreg_r[idx_r*CHUNK +: CHUNK];
    assign last_s  = (idx_r == IW'(N - 1));

    hdc_popcount #(.W(CHUNK), .CW(CW)) u_pop_ham (
        .bits  (xor_h_s),
        .count (cnt_h_s)
    );

    hdc_popcount #(.W(CHUNK), .CW(CW)) u_pop_spam (
        .bits  (xor_s_s),
        .count (cnt_s_s)
    );

    // Next-state logic; start is only looked at in IDLE so it is never queued.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_s) begin
                    state_next_s = ST_DECIDE;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_DECIDE: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture on accept, then chunk-wise distance accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qreg_r  <= {DIM{1'b0}};
            hreg_r  <= {DIM{1'b0}};
            sreg_r  <= {DIM{1'b0}};
            acc_h_r <= {DW{1'b0}};
            acc_s_r <= {DW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        qreg_r  <= query;
                        hreg_r  <= ham_hv;
                        sreg_r  <= spam_hv;
                        acc_h_r <= {DW{1'b0}};
                        acc_s_r <= {DW{1'b0}};
                        idx_r   <= {IW{1'b0}};
                    end
                end
                ST_ACCUM: begin
                    acc_h_r <= acc_h_r + DW'(cnt_h_s);
                    acc_s_r <= acc_s_r + DW'(cnt_s_s);
                    idx_r   <= idx_r + IW'(1'b1);
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Registered outputs; result and distances hold until the next decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= LABEL_INCONCL;
            dist_ham_r  <= {DW{1'b0}};
            dist_spam_r <= {DW{1'b0}};
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_r == ST_DECIDE);
            if (state_r == ST_DECIDE) begin
                dist_ham_r  <= acc_h_r;
                dist_spam_r <= acc_s_r;
                result_r    <= classify_label(32'(acc_h_r), 32'(acc_s_r), 32'(MARGIN));
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign dist_ham  = dist_ham_r;
    assign dist_spam = dist_spam_r;

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Directed self-checking bench for hdc_assoc_search: a MARGIN=0 instance and a MARGIN=8 instance.
module tb_hdc_assoc_search;

    localparam int DIM = 1024;
    localparam int DW  = 11;

    logic            clk;
    logic            reset;
    logic            start0;
    logic            start1;
    logic [DIM-1:0]  query;
    logic [DIM-1:0]  ham_hv;
    logic [DIM-1:0]  spam_hv;
    logic            busy0, done0, busy1, done1;
    logic [1:0]      result0, result1;
    logic [DW-1:0]   dist_ham0, dist_spam0, dist_ham1, dist_spam1;

    int total = 0;
    int bad   = 0;

    hdc_assoc_search #(.DIM(DIM), .CHUNK(64), .MARGIN(0)) dut (
        .clk(clk), .reset(reset), .start(start0),
        .query(query), .ham_hv(ham_hv), .spam_hv(spam_hv),
        .busy(busy0), .done(done0), .result(result0),
        .dist_ham(dist_ham0), .dist_spam(dist_spam0)
    );

    hdc_assoc_search #(.DIM(DIM), .CHUNK(64), .MARGIN(8)) dut_m (
        .clk(clk), .reset(reset), .start(start1),
        .query(query), .ham_hv(ham_hv), .spam_hv(spam_hv),
        .busy(busy1), .done(done1), .result(result1),
        .dist_ham(dist_ham1), .dist_spam(dist_spam1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Vector with bits lo..hi-1 set.
    function automatic logic [DIM-1:0] ones_range(input int lo, input int hi);
        logic [DIM-1:0] v;
        v = '0;
        for (int i = lo; i < hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic sel_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    function automatic logic sel_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    // One pulse of start; returns cycles from accept edge to done and busy-high cycles seen.
    task automatic run_search(input int sel, output int lat, output int busy_cnt);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!sel_done(sel) && lat < 64) begin
            if (sel_busy(sel)) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat, bcnt, n;
    logic seen;
    logic [DIM-1:0] rnd;

    initial begin
        reset   = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        query   = '0;
        ham_hv  = '0;
        spam_hv = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst result", result0, 2'b11);
        chk("rst dist_ham", dist_ham0, 0);
        chk("rst dist_spam", dist_spam0, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: query equals ham, spam is its complement
        for (int i = 0; i < DIM; i++) rnd[i] = $urandom_range(0, 1);
        ham_hv = rnd; spam_hv = ~rnd; query = rnd;
        run_search(0, lat, bcnt);
        chk("t1 latency", lat, 17);
        chk("t1 busy cycles", bcnt, 17);
        chk("t1 busy at done", busy0, 0);
        chk("t1 dist_ham", dist_ham0, 0);
        chk("t1 dist_spam", dist_spam0, 1024);
        chk("t1 result", result0, 2'b00);
        @(posedge clk); #1;
        chk("t1 done pulse", done0, 0);
        chk("t1 result hold", result0, 2'b00);

        // 2: query equals spam; ham differs in 300 bits
        spam_hv = ones_range(0, 300); ham_hv = '0; query = spam_hv;
        run_search(0, lat, bcnt);
        chk("t2 latency", lat, 17);
        chk("t2 busy cycles", bcnt, 17);
        chk("t2 dist_ham", dist_ham0, 300);
        chk("t2 dist_spam", dist_spam0, 0);
        chk("t2 result", result0, 2'b01);

        // 3: identical prototypes tie
        ham_hv = ones_range(0, 100); spam_hv = ham_hv; query = ones_range(0, 40);
        run_search(0, lat, bcnt);
        chk("t3 dist_ham", dist_ham0, 60);
        chk("t3 dist_spam", dist_spam0, 60);
        chk("t3 result", result0, 2'b11);

        // 4: margin of 8 on the second instance
        query = ones_range(0, 500); ham_hv = '0; spam_hv = ones_range(500, 505);
        run_search(1, lat, bcnt);
        chk("t4 latency", lat, 17);
        chk("t4 505 dist_spam", dist_spam1, 505);
        chk("t4 505 result", result1, 2'b11);
        spam_hv = ones_range(500, 508);
        run_search(1, lat, bcnt);
        chk("t4 508 result", result1, 2'b11);
        spam_hv = ones_range(500, 509);
        run_search(1, lat, bcnt);
        chk("t4 509 dist_ham", dist_ham1, 500);
        chk("t4 509 dist_spam", dist_spam1, 509);
        chk("t4 509 result", result1, 2'b00);

        // 5: start held high, inputs changed right after accept
        query = rnd; ham_hv = rnd; spam_hv = ~rnd;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        query = ones_range(0, 300); ham_hv = '0; spam_hv = ones_range(0, 300);
        lat = 0;
        while (!done0 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t5 first latency", lat, 17);
        chk("t5 first dist_spam", dist_spam0, 1024);
        chk("t5 first result", result0, 2'b00);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done0 && n < 64);
        start0 = 1'b0;
        chk("t5 second gap", n, 18);
        chk("t5 second dist_ham", dist_ham0, 300);
        chk("t5 second result", result0, 2'b01);
        repeat (2) @(posedge clk);
        #1;
        chk("t5 no third accept", busy0, 0);

        // 6: reset in the middle of accumulation
        query = ones_range(0, 1024); ham_hv = '0; spam_hv = ones_range(0, 1000);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6 busy", busy0, 0);
        chk("t6 done", done0, 0);
        chk("t6 result", result0, 2'b11);
        chk("t6 dist_ham", dist_ham0, 0);
        chk("t6 dist_spam", dist_spam0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0) seen = 1'b1;
        end
        chk("t6 no done after abort", seen, 0);
        run_search(0, lat, bcnt);
        chk("t6 new latency", lat, 17);
        chk("t6 new dist_ham", dist_ham0, 1024);
        chk("t6 new dist_spam", dist_spam0, 24);
        chk("t6 new result", result0, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
